// File: rtl/wb_arb_pkg.sv
// Shared types for the write-port arbiter: SAD FIFO entry layout, arbiter
// state encoding and the hard-wired zero register index.
// Latency: n/a (types only). Backpressure: n/a.
package wb_arb_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic        valid;  // cleared when a newer pipeline write targets rd
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FORCE = 2'd2
  } state_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle of the arbiter's WB-stage, SAD-engine, register-file and hazard signals.
// slave = arbiter side, master = surrounding pipeline/bench side.
// Optional Pending_Mask exists only when WBARB_PENDING_SCOREBOARD_EN is defined.
interface wb_port_arbiter_if #(parameter int DEPTH = 4);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          WB_RegWrite;
  logic [4:0]    WB_WriteReg;
  logic [31:0]   WB_WriteData;
  logic          SAD_Valid;
  logic          SAD_Ready;
  logic [4:0]    SAD_WriteReg;
  logic [31:0]   SAD_Value;
  logic          RF_RegWrite;
  logic [4:0]    RF_WriteReg;
  logic [31:0]   RF_WriteData;
  logic          Stall_Req;
  logic [CW-1:0] Fifo_Count;
`ifdef WBARB_PENDING_SCOREBOARD_EN
  logic [31:0]   Pending_Mask;
`endif

  modport slave (
    input  WB_RegWrite, WB_WriteReg, WB_WriteData,
    input  SAD_Valid, SAD_WriteReg, SAD_Value,
    output SAD_Ready,
    output RF_RegWrite, RF_WriteReg, RF_WriteData,
    output Stall_Req, Fifo_Count
`ifdef WBARB_PENDING_SCOREBOARD_EN
    , output Pending_Mask
`endif
  );

  modport master (
    output WB_RegWrite, WB_WriteReg, WB_WriteData,
    output SAD_Valid, SAD_WriteReg, SAD_Value,
    input  SAD_Ready,
    input  RF_RegWrite, RF_WriteReg, RF_WriteData,
    input  Stall_Req, Fifo_Count
`ifdef WBARB_PENDING_SCOREBOARD_EN
    , input Pending_Mask
`endif
  );

endinterface

// File: rtl/wb_arb_fifo.sv
// Circular buffer of SAD results with a kill-by-destination port.
// Latency: push visible at head one cycle later; head is a registered read.
// Backpressure: full_o; caller must not push when full or pop when empty.
// Ports: clk_i/rst_i (sync, active-high), push_i/push_entry_i, pop_i,
//   kill_i/kill_reg_i (invalidate every stored entry targeting kill_reg_i),
//   head_o, count_o, full_o, valid_mask_o (WBARB_PENDING_SCOREBOARD_EN only).
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  entry_t                     push_entry_i,
  input  logic                       pop_i,
  input  logic                       kill_i,
  input  logic [4:0]                 kill_reg_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o
`ifdef WBARB_PENDING_SCOREBOARD_EN
  , output logic [31:0]              valid_mask_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;

  // Popped slots get their valid bit cleared, so valid bits alone describe
  // live entries and the pending mask needs no occupancy test.
  always_comb begin
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (kill_i && (mem_q[i].rd == kill_reg_i)) mem_d[i].valid = 1'b0;
    end
    if (pop_i) mem_d[head_q].valid = 1'b0;
    // Written after the kill so a same-cycle push to the killed register survives.
    if (push_i) mem_d[tail_q] = push_entry_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_q + PW'(pop_i);
      tail_q  <= tail_q + PW'(push_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign head_o  = mem_q[head_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));

`ifdef WBARB_PENDING_SCOREBOARD_EN
  always_comb begin
    valid_mask_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem_q[i].valid) valid_mask_o[mem_q[i].rd] = 1'b1;
    end
    valid_mask_o[0] = 1'b0;
  end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline WB writes (always win)
// and queued SAD results that drain into free WB slots; 0-cycle port mux.
// Backpressure: SAD_Ready = !full; Stall_Req requests a bubble after MAX_WAIT busy cycles.
// Ports: Clk, Rst (sync, active-high), bus (wb_port_arbiter_if.slave).
// Optional feature macro: WBARB_PENDING_SCOREBOARD_EN adds bus.Pending_Mask.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input logic               Clk,
  input logic               Rst,
  wb_port_arbiter_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  entry_t        head, push_entry;
  logic [CW-1:0] count, count_nxt;
  logic          full, free, push, pop, fifo_wr, sad_ready;
  state_t        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
`ifdef WBARB_PENDING_SCOREBOARD_EN
  logic [31:0]   pend_mask;
`endif

  // A pipeline write to $0 is a no-op, so it leaves the slot free.
  assign free      = !bus.WB_RegWrite || (bus.WB_WriteReg == REG_ZERO);
  assign fifo_wr   = free && head.valid;
  // A killed head is discarded on the next edge regardless of slot usage.
  assign pop       = (count != '0) && (!head.valid || free);
  assign sad_ready = !Rst && !full;
  // Results for $0 complete the handshake but are dropped.
  assign push      = sad_ready && bus.SAD_Valid && (bus.SAD_WriteReg != REG_ZERO);
  assign push_entry = '{valid: 1'b1, rd: bus.SAD_WriteReg, data: bus.SAD_Value};
  assign count_nxt = count + CW'(push) - CW'(pop);

  wb_arb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i        (Clk),
    .rst_i        (Rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .kill_i       (!free),
    .kill_reg_i   (bus.WB_WriteReg),
    .head_o       (head),
    .count_o      (count),
    .full_o       (full)
`ifdef WBARB_PENDING_SCOREBOARD_EN
    , .valid_mask_o (pend_mask)
`endif
  );

  always_comb begin
    bus.RF_RegWrite  = 1'b0;
    bus.RF_WriteReg  = '0;
    bus.RF_WriteData = '0;
    if (!Rst) begin
      if (!free) begin
        bus.RF_RegWrite  = 1'b1;
        bus.RF_WriteReg  = bus.WB_WriteReg;
        bus.RF_WriteData = bus.WB_WriteData;
      end else if (fifo_wr) begin
        bus.RF_RegWrite  = 1'b1;
        bus.RF_WriteReg  = head.rd;
        bus.RF_WriteData = head.data;
      end
    end
  end

  assign bus.SAD_Ready  = sad_ready;
  assign bus.Stall_Req  = !Rst && (state_q == FORCE);
  assign bus.Fifo_Count = Rst ? '0 : count;
`ifdef WBARB_PENDING_SCOREBOARD_EN
  assign bus.Pending_Mask = pend_mask;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (push) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop) begin
          wait_d = '0;
        end else if (head.valid && !free) begin
          wait_d = wait_q + WW'(1);
          if (wait_d == WW'(MAX_WAIT)) state_d = FORCE;
        end
      end
      FORCE: begin
        // Hold the stall request until a real write from the FIFO happens;
        // discarding a killed head does not satisfy a waiting valid entry.
        if (fifo_wr) begin
          wait_d  = '0;
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = '0;
      end
    endcase
    if (count_nxt == '0) begin
      state_d = IDLE;
      wait_d  = '0;
    end
  end

endmodule
